// File: rtl/score_digit_renderer_pkg.sv
// Shared leaderboard definitions: glyph geometry, converter FSM states and
// the decimal saturation helper used by the score digit renderer.
package score_digit_renderer_pkg;

    localparam int GLYPH_W     = 30;
    localparam int GLYPH_H     = 30;
    localparam int GLYPH_SIZE  = GLYPH_W * GLYPH_H;
    localparam int GLYPH_COUNT = 10;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } bcd_state_t;

    // Largest value representable with the given number of decimal digits.
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/score_digit_renderer_if.sv
// Bundle of the score-load handshake, raster pixel stream and glyph ROM
// signals of the score digit renderer.
interface score_digit_renderer_if #(
    parameter int SCORE_W    = 20,
    parameter int NUM_DIGITS = 6,
    parameter int ROM_AW     = 14
) ();

    logic [SCORE_W-1:0]      score_in;
    logic                    score_load;
    logic                    busy;
    logic                    bcd_valid;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [9:0]              pix_x;
    logic [9:0]              pix_y;
    logic                    pix_valid;
    logic [ROM_AW-1:0]       rom_addr;
    logic                    rom_q;
    logic                    pixel_on;
    logic                    pixel_valid;

    modport master (
        output score_in, score_load, pix_x, pix_y, pix_valid, rom_q,
        input  busy, bcd_valid, digits_out, rom_addr, pixel_on, pixel_valid
    );

    modport slave (
        input  score_in, score_load, pix_x, pix_y, pix_valid, rom_q,
        output busy, bcd_valid, digits_out, rom_addr, pixel_on, pixel_valid
    );

endinterface

// File: rtl/score_digit_renderer_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, committed result
// is held in digits_out until the next completed conversion.
module bin2bcd_seq
    import score_digit_renderer_pkg::*;
#(
    parameter int SCORE_W    = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SCORE_W-1:0]      score_in,
    input  logic                    score_load,
    output logic                    busy,
    output logic                    bcd_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out
);

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          CNT_W     = $clog2(SCORE_W + 1);
    localparam logic [63:0] SAT_LIMIT = max_decimal(NUM_DIGITS);

    bcd_state_t         state, next_state;
    logic [SCORE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   iter_q;
    logic [SCORE_W-1:0] operand;
    logic               last_iter;
    logic               do_load;
    logic               do_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (score_load) next_state = CONVERT;
            CONVERT: if (last_iter)  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CONVERT);
        do_load   = (state == IDLE) && score_load;
        do_commit = (state == COMMIT);
    end

    // Scores beyond the display range are clamped to all nines.
    always_comb begin
        last_iter = (iter_q == CNT_W'(SCORE_W - 1));
        operand   = score_in;
        if (64'(score_in) > SAT_LIMIT) begin
            operand = SAT_LIMIT[SCORE_W-1:0];
        end
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            digits_out <= '0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= do_commit;
            if (do_load) begin
                bin_q  <= operand;
                bcd_q  <= '0;
                iter_q <= '0;
            end else if (busy) begin
                bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_q  <= {bin_q[SCORE_W-2:0], 1'b0};
                iter_q <= iter_q + 1'b1;
            end
            if (do_commit) begin
                digits_out <= bcd_q;
            end
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score digit renderer: BCD conversion of the score plus a 3-stage pipeline
// mapping raster coordinates to glyph ROM addresses and lit pixels.
module score_digit_renderer #(
    parameter int NUM_DIGITS = 6,
    parameter int SCORE_W    = 20,
    parameter int GLYPH_W    = score_digit_renderer_pkg::GLYPH_W,
    parameter int GLYPH_H    = score_digit_renderer_pkg::GLYPH_H,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int BLANK_LZ   = 1,
    parameter int ROM_AW     = 14
) (
    input logic              clk,
    input logic              reset,
    score_digit_renderer_if.slave bus
);

    import score_digit_renderer_pkg::*;

    localparam int                IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0]       X_LO         = 32'(ORIGIN_X);
    localparam logic [31:0]       Y_LO         = 32'(ORIGIN_Y);
    localparam logic [ROM_AW-1:0] GLYPH_SIZE_A = ROM_AW'(GLYPH_W * GLYPH_H);
    localparam logic [ROM_AW-1:0] GLYPH_W_A    = ROM_AW'(GLYPH_W);

    logic [31:0]           x_rel, y_rel;
    logic [IDX_W-1:0]      pos_c;
    logic [9:0]            col_base;
    logic [9:0]            col_c;
    logic [3:0]            digit_c;
    logic                  in_box_c;
    logic                  blank_c;
    logic                  run_zero;
    logic [NUM_DIGITS-1:0] blank_mask;

    logic       s1_valid, s1_in_box, s1_blank;
    logic [3:0] s1_digit;
    logic [9:0] s1_row, s1_col;
    logic       s2_valid, s2_in_box, s2_blank;

    bin2bcd_seq #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk        (clk),
        .reset      (reset),
        .score_in   (bus.score_in),
        .score_load (bus.score_load),
        .busy       (bus.busy),
        .bcd_valid  (bus.bcd_valid),
        .digits_out (bus.digits_out)
    );

    // A digit is blank when it and everything more significant are zero.
    always_comb begin
        blank_mask = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero      = run_zero & (bus.digits_out[4*i +: 4] == 4'd0);
            blank_mask[i] = run_zero & (BLANK_LZ != 0);
        end
    end

    // Coordinates left of/above the origin wrap to huge values and fall out of box.
    always_comb begin
        x_rel    = 32'(bus.pix_x) - X_LO;
        y_rel    = 32'(bus.pix_y) - Y_LO;
        in_box_c = bus.pix_valid && (x_rel < 32'(NUM_DIGITS * GLYPH_W))
                                 && (y_rel < 32'(GLYPH_H));
        pos_c    = '0;
        col_base = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (x_rel >= 32'(k * GLYPH_W)) begin
                pos_c    = IDX_W'(k);
                col_base = 10'(k * GLYPH_W);
            end
        end
        col_c   = x_rel[9:0] - col_base;
        digit_c = '0;
        blank_c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(NUM_DIGITS - 1 - i) == pos_c) begin
                digit_c = bus.digits_out[4*i +: 4];
                blank_c = blank_mask[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_in_box <= 1'b0;
            s1_blank  <= 1'b0;
            s1_digit  <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
        end else begin
            s1_valid  <= bus.pix_valid;
            s1_in_box <= in_box_c;
            s1_blank  <= blank_c;
            s1_digit  <= digit_c;
            s1_row    <= y_rel[9:0];
            s1_col    <= col_c;
        end
    end

    // The ROM address only moves for in-box pixels to avoid needless ROM toggling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rom_addr <= '0;
            s2_valid     <= 1'b0;
            s2_in_box    <= 1'b0;
            s2_blank     <= 1'b0;
        end else begin
            if (s1_in_box) begin
                bus.rom_addr <= GLYPH_SIZE_A * ROM_AW'(s1_digit)
                              + GLYPH_W_A * ROM_AW'(s1_row)
                              + ROM_AW'(s1_col);
            end
            s2_valid  <= s1_valid;
            s2_in_box <= s1_in_box;
            s2_blank  <= s1_blank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pixel_on    <= 1'b0;
            bus.pixel_valid <= 1'b0;
        end else begin
            bus.pixel_on    <= bus.rom_q & s2_in_box & ~s2_blank;
            bus.pixel_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed self-checking bench for score_digit_renderer with default
// geometry (6 digits of 30x30 at the origin, leading-zero blanking on).
module tb_score_digit_renderer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   rom_mode = 0;

    always #5 clk = ~clk;

    score_digit_renderer_if #(.SCORE_W(20), .NUM_DIGITS(6), .ROM_AW(14)) bus ();

    score_digit_renderer #(
        .NUM_DIGITS (6),
        .SCORE_W    (20),
        .GLYPH_W    (30),
        .GLYPH_H    (30),
        .ORIGIN_X   (0),
        .ORIGIN_Y   (0),
        .BLANK_LZ   (1),
        .ROM_AW     (14)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Glyph ROM stand-in: constant 0, constant 1, or the address LSB.
    always_comb begin
        case (rom_mode)
            0:       bus.rom_q = 1'b0;
            1:       bus.rom_q = 1'b1;
            default: bus.rom_q = bus.rom_addr[0];
        endcase
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int x, input int y, input logic v);
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
        bus.pix_valid = v;
    endtask

    task automatic load_score(input logic [19:0] v);
        bus.score_in   = v;
        bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.bcd_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic probe(input int x, input int y, output logic [13:0] addr,
                         output logic on, output logic pv);
        apply_stimulus(x, y, 1'b1);
        tick();
        apply_stimulus(0, 0, 1'b0);
        tick();
        addr = bus.rom_addr;
        tick();
        on = bus.pixel_on;
        pv = bus.pixel_valid;
    endtask

    logic [13:0] addr;
    logic        on, pv;
    int          lat, pulses, busy_cycles;
    logic [23:0] snap;
    logic        exp_v  [0:199];
    logic        exp_on [0:199];

    initial begin
        reset          = 1'b1;
        bus.score_in   = '0;
        bus.score_load = 1'b0;
        apply_stimulus(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy",        32'(bus.busy),        0);
        check_output("rst_bcd_valid",   32'(bus.bcd_valid),   0);
        check_output("rst_digits",      32'(bus.digits_out),  0);
        check_output("rst_rom_addr",    32'(bus.rom_addr),    0);
        check_output("rst_pixel_on",    32'(bus.pixel_on),    0);
        check_output("rst_pixel_valid", 32'(bus.pixel_valid), 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a conversion discards it.
        load_score(20'd999);
        repeat (5) tick();
        check_output("busy_mid_convert", 32'(bus.busy), 1);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst_busy",   32'(bus.busy),       0);
        check_output("async_rst_digits", 32'(bus.digits_out), 0);
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.bcd_valid) pulses++;
        end
        check_output("no_pulse_after_rst", 32'(pulses), 0);
        check_output("digits_after_rst",   32'(bus.digits_out), 0);

        // Saturation plus a load attempt while busy.
        load_score(20'd1000000);
        tick();
        tick();
        bus.score_in   = 20'd5;
        bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        check_output("busy_during_ignored_load", 32'(bus.busy), 1);
        wait_valid(lat);
        check_output("sat_latency", 32'(lat + 3), 21);
        check_output("sat_digits",  32'(bus.digits_out), 32'h999999);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.bcd_valid) pulses++;
        end
        check_output("no_queued_load", 32'(pulses), 0);
        check_output("sat_digits_hold", 32'(bus.digits_out), 32'h999999);

        // 1234: busy window, pulse timing, no early update of digits_out.
        load_score(20'd1234);
        busy_cycles = bus.busy ? 1 : 0;
        lat  = 0;
        snap = '0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (bus.busy) busy_cycles++;
            if (bus.bcd_valid && lat == 0) lat = i;
            if (i == 20) snap = bus.digits_out;
        end
        check_output("busy_cycles_1234", 32'(busy_cycles), 20);
        check_output("latency_1234",     32'(lat), 21);
        check_output("no_tearing",       32'(snap), 32'h999999);
        check_output("digits_1234",      32'(bus.digits_out), 32'h001234);

        // Pixel address generation: "  1234", x=95 is glyph '2', x=122 is glyph '3'.
        rom_mode = 2;
        probe(95, 2, addr, on, pv);
        check_output("addr_x95_y2",  32'(addr), 1865);
        check_output("on_x95_y2",    32'(on), 1);
        check_output("pv_x95_y2",    32'(pv), 1);
        probe(122, 3, addr, on, pv);
        check_output("addr_x122_y3", 32'(addr), 2792);
        check_output("on_x122_y3",   32'(on), 0);

        // Leading-zero blanking with the ROM forced to 1.
        rom_mode = 1;
        probe(10, 0, addr, on, pv);
        check_output("blank_pos0", 32'(on), 0);
        probe(40, 0, addr, on, pv);
        check_output("blank_pos1", 32'(on), 0);
        probe(70, 0, addr, on, pv);
        check_output("addr_pos2",  32'(addr), 910);
        check_output("lit_pos2",   32'(on), 1);

        // Score 0 keeps the units digit visible.
        load_score(20'd0);
        wait_valid(lat);
        check_output("latency_zero", 32'(lat), 21);
        check_output("digits_zero",  32'(bus.digits_out), 0);
        probe(155, 5, addr, on, pv);
        check_output("addr_zero_pos5", 32'(addr), 155);
        check_output("on_zero_rom1",   32'(on), 1);
        rom_mode = 0;
        probe(155, 5, addr, on, pv);
        check_output("on_zero_rom0",   32'(on), 0);
        rom_mode = 1;
        probe(125, 5, addr, on, pv);
        check_output("blank_zero_pos4", 32'(on), 0);

        // Streaming row with toggling pix_valid and out-of-box pixels.
        load_score(20'd1234);
        wait_valid(lat);
        check_output("latency_reload", 32'(lat), 21);
        for (int t = 0; t < 185; t++) begin
            int   px, py;
            logic v;
            if (t >= 3) begin
                check_output("stream_pixel_valid", 32'(bus.pixel_valid), 32'(exp_v[t-3]));
                check_output("stream_pixel_on",    32'(bus.pixel_on),    32'(exp_on[t-3]));
            end
            if (t < 180) begin
                px = t;   py = 7;  v = ((t % 3) != 0);
            end else if (t == 180) begin
                px = 180; py = 7;  v = 1'b1;
            end else if (t == 181) begin
                px = 100; py = 30; v = 1'b1;
            end else begin
                px = 0;   py = 0;  v = 1'b0;
            end
            apply_stimulus(px, py, v);
            exp_v[t]  = v;
            exp_on[t] = v && (py < 30) && (px < 180) && (px >= 60);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
